// File: rtl/radix4_approx_mult_seq_pkg.sv
// Shared types and the digit-recoding rule for the sequential radix-4 approximate multiplier.
// The bench imports eff_digit so that hardware and reference model agree on which digits are approximated.
package radix4_approx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SEL_0  = 3'd0,
      SEL_X  = 3'd1,
      SEL_2X = 3'd2,
      SEL_3X = 3'd3,
      SEL_4X = 3'd4
   } sel_t;

   // A digit of 3 inside the approximation window becomes 4, so 3x is never needed there.
   function automatic sel_t eff_digit(input logic [1:0]  d,
                                      input int unsigned idx,
                                      input logic        approx,
                                      input int unsigned approx_digits);
      sel_t sel;
      case (d)
         2'd0:    sel = SEL_0;
         2'd1:    sel = SEL_X;
         2'd2:    sel = SEL_2X;
         default: sel = (approx && (idx < approx_digits)) ? SEL_4X : SEL_3X;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/radix4_approx_mult_seq_pp_sel.sv
// Partial-product mux: picks 0, x, 2x, 3x or 4x for the current radix-4 digit.
// 4x and 2x are free shifts; 3x arrives precomputed from the top.
module radix4_pp_sel
   import radix4_approx_pkg::*;
#(
   parameter int unsigned WIDTH         = 34,
   parameter int unsigned APPROX_DIGITS = 8,
   parameter int unsigned CW            = 5
) (
   input  logic [1:0]       digit,
   input  logic [CW-1:0]    idx,
   input  logic             approx,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH+1:0] x3,
   output logic [WIDTH+1:0] pp
);

   sel_t sel;

   always_comb begin
      // NOTE: pp gets a default before the case so no path leaves it unassigned (no latch).
      pp  = '0;
      sel = eff_digit(digit, 32'(idx), approx, APPROX_DIGITS);
      case (sel)
         SEL_X:   pp = {2'b00, x};
         SEL_2X:  pp = {1'b0, x, 1'b0};
         SEL_3X:  pp = x3;
         SEL_4X:  pp = {x, 2'b00};
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/radix4_approx_mult_seq.sv
// Iterative radix-4 approximate unsigned multiplier: one multiplier digit per clock,
// valid/ready on both sides, product held until the consumer takes it.
module radix4_approx_mult_seq #(
   parameter int unsigned WIDTH         = 34,
   parameter int unsigned APPROX_DIGITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   input  logic                 approx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p
);
   import radix4_approx_pkg::*;

   localparam int unsigned NDIG = WIDTH / 2;
   localparam int unsigned CW   = $clog2(NDIG);
   localparam int unsigned AW   = 2 * WIDTH + 2;
   localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   x_reg;
   logic [WIDTH-1:0]   y_reg;
   logic [WIDTH+1:0]   x3_reg;
   logic               approx_reg;
   logic [AW-1:0]      acc;

   logic [WIDTH+1:0]   x3_in;
   logic [WIDTH+1:0]   pp;
   logic [WIDTH+2:0]   sum_hi;
   logic [AW-1:0]      acc_next;

   assign in_ready = (state == IDLE);
   assign p        = acc[2*WIDTH-1:0];
   assign x3_in    = {2'b00, x} + {1'b0, x, 1'b0};

   radix4_pp_sel #(
      .WIDTH         (WIDTH),
      .APPROX_DIGITS (APPROX_DIGITS),
      .CW            (CW)
   ) u_pp_sel (
      .digit  (y_reg[1:0]),
      .idx    (cnt),
      .approx (approx_reg),
      .x      (x_reg),
      .x3     (x3_reg),
      .pp     (pp)
   );

   // Each partial product enters at bit WIDTH and the whole accumulator drifts down two
   // bits per digit, so after NDIG digits the first one lands at bit 0. The shifted-out
   // bits are always zero, which keeps the product exact modulo 2^(2*WIDTH).
   assign sum_hi   = {1'b0, acc[AW-1:WIDTH]} + {1'b0, pp};
   assign acc_next = AW'({sum_hi, acc[WIDTH-1:2]});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         x_reg      <= '0;
         y_reg      <= '0;
         x3_reg     <= '0;
         approx_reg <= 1'b0;
         acc        <= '0;
         out_valid  <= 1'b0;
      end else begin
         // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_reg      <= x;
                  y_reg      <= y;
                  x3_reg     <= x3_in;
                  approx_reg <= approx;
                  acc        <= '0;
                  cnt        <= '0;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               acc   <= acc_next;
               y_reg <= y_reg >> 2;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST_IDX) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_radix4_approx_mult_seq.sv
// Directed bench for radix4_approx_mult_seq: scoreboarded products, latency, backpressure,
// asynchronous reset mid-operation, and a second instance with a full-width approximation window.
module tb_radix4_approx_mult_seq;
   import radix4_approx_pkg::*;

   localparam int unsigned W = 34;
   localparam int unsigned K = W / 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid, in_ready, approx, out_valid, out_ready;
   logic [W-1:0]      x, y;
   logic [2*W-1:0]    p;

   logic              b_in_valid, b_in_ready, b_approx, b_out_valid, b_out_ready;
   logic [W-1:0]      b_x, b_y;
   logic [2*W-1:0]    b_p;

   int total = 0;
   int bad   = 0;
   logic [2*W-1:0] exp_q[$];

   always #5 clk = ~clk;

   radix4_approx_mult_seq #(.WIDTH(W), .APPROX_DIGITS(8)) u_dut (
      .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
      .x (x), .y (y), .approx (approx), .out_valid (out_valid),
      .out_ready (out_ready), .p (p)
   );

   radix4_approx_mult_seq #(.WIDTH(W), .APPROX_DIGITS(17)) u_dut_full (
      .clk (clk), .rst_n (rst_n), .in_valid (b_in_valid), .in_ready (b_in_ready),
      .x (b_x), .y (b_y), .approx (b_approx), .out_valid (b_out_valid),
      .out_ready (b_out_ready), .p (b_p)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: build the effective multiplier value digit by digit, then one wide multiply.
   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] xx, input logic [W-1:0] yy,
                                               input logic a, input int unsigned ad);
      logic [127:0] m;
      logic [127:0] prod;
      m = '0;
      for (int unsigned i = 0; i < K; i++) begin
         sel_t         s;
         logic [127:0] v;
         s = eff_digit(yy[2*i +: 2], i, a, ad);
         case (s)
            SEL_X:   v = 128'd1;
            SEL_2X:  v = 128'd2;
            SEL_3X:  v = 128'd3;
            SEL_4X:  v = 128'd4;
            default: v = 128'd0;
         endcase
         m = m + (v << (2 * i));
      end
      prod = 128'(xx) * m;
      return prod[2*W-1:0];
   endfunction

   task automatic start_op(input logic [W-1:0] xx, input logic [W-1:0] yy, input logic a,
                           input logic [2*W-1:0] e);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_accept", 128'(in_ready), 128'd1);
      in_valid = 1'b1;
      x        = xx;
      y        = yy;
      approx   = a;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x        = '0;
      y        = '0;
      approx   = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", 128'(n), 128'(K));
   endtask

   task automatic collect(input string tag);
      logic [2*W-1:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      check(tag, 128'(p), 128'(e));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("out_valid_after_handshake", 128'(out_valid), 128'd0);
      check("in_ready_after_handshake", 128'(in_ready), 128'd1);
   endtask

   task automatic b_op(input logic [W-1:0] xx, input logic [W-1:0] yy, input logic a,
                       input logic [2*W-1:0] e, input string tag);
      int n = 0;
      @(negedge clk);
      check("full_in_ready", 128'(b_in_ready), 128'd1);
      b_in_valid = 1'b1;
      b_x        = xx;
      b_y        = yy;
      b_approx   = a;
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      while (!b_out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("full_latency", 128'(n), 128'(K));
      check(tag, 128'(b_p), 128'(e));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0]   ones;
      logic [2*W-1:0] fs_exp;
      ones   = '1;
      fs_exp = ({(2*W){1'b1}} << (W + 1)) + (2*W)'(1);

      rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; approx = 1'b0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_x = '0; b_y = '0; b_approx = 1'b0; b_out_ready = 1'b1;

      #2;
      check("reset_in_ready", 128'(in_ready), 128'd1);
      check("reset_out_valid", 128'(out_valid), 128'd0);
      check("reset_p", 128'(p), 128'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("in_ready_after_release", 128'(in_ready), 128'd1);

      start_op(3, 3, 1'b0, 9);
      wait_done();
      collect("exact_3x3");

      start_op(1, 'hF, 1'b1, 20);
      wait_done();
      collect("approx_1xF");

      start_op(1, 'hF, 1'b0, 15);
      wait_done();
      collect("exact_1xF");

      start_op(5, 3 << 16, 1'b1, 983040);
      wait_done();
      collect("outside_window");

      start_op(ones, ones, 1'b0, fs_exp);
      wait_done();
      collect("full_scale_exact");

      start_op(ones, ones, 1'b1, ref_prod(ones, ones, 1'b1, 8));
      wait_done();
      collect("full_scale_approx8");

      // Backpressure: result held for 5 cycles while stray x=9 requests must be ignored.
      start_op(11, 13, 1'b0, 143);
      wait_done();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         x        = 9;
         y        = 9;
         check("bp_p_stable", 128'(p), 128'd143);
         check("bp_in_ready", 128'(in_ready), 128'd0);
         check("bp_out_valid", 128'(out_valid), 128'd1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         x        = '0;
         y        = '0;
      end
      collect("bp_result");
      start_op(2, 3, 1'b0, 6);
      wait_done();
      collect("after_bp");

      // Reset during the 8th digit cycle drops the operation without any output.
      start_op(100, 200, 1'b0, 20000);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset_out_valid", 128'(out_valid), 128'd0);
      check("midreset_p", 128'(p), 128'd0);
      check("midreset_in_ready", 128'(in_ready), 128'd1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("no_output_after_reset", 128'(out_valid), 128'd0);
      start_op(7, 6, 1'b0, 42);
      wait_done();
      collect("post_reset_7x6");

      for (int i = 0; i < 4; i++) begin
         logic [W-1:0] xx;
         logic [W-1:0] yy;
         logic         a;
         xx = W'({$urandom(), $urandom()});
         yy = W'({$urandom(), $urandom()});
         a  = i[0];
         start_op(xx, yy, a, ref_prod(xx, yy, a, 8));
         wait_done();
         collect("random_op");
      end

      b_op(ones, ones, 1'b1, ref_prod(ones, ones, 1'b1, 17), "full_window_approx");
      b_op(ones, ones, 1'b0, fs_exp, "full_window_exact");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
